// File: rtl/bcd_para_binario_pkg.sv
// Shared definitions for the BCD<->binary conversion paths: special display
// codes, their BCD digit encodings and the converter state machine states.
package bcd_para_binario_pkg;

    localparam int unsigned CODIGO_TRACO   = 125;
    localparam int unsigned CODIGO_APAGADO = 124;

    localparam logic [3:0] DIGITO_TRACO   = 4'd15;
    localparam logic [3:0] DIGITO_APAGADO = 4'd14;

    typedef enum logic [1:0] {
        OCIOSO,
        CONVERTE,
        PRONTO
    } estado_t;

endpackage

// File: rtl/bcd_para_binario_if.sv
// Handshake/data bundle of the BCD-to-binary converter.
// The erro signal exists only when BCD_BIN_ERRO_EN is defined.
interface bcd_para_binario_if #(
    parameter int unsigned N_BITS = 7
);

    logic              start;
    logic [3:0]        dezena;
    logic [3:0]        unidade;
    logic [N_BITS-1:0] binario;
    logic              ocupado;
    logic              pronto;
`ifdef BCD_BIN_ERRO_EN
    logic              erro;

    modport master (output start, dezena, unidade,
                    input  binario, ocupado, pronto, erro);
    modport slave  (input  start, dezena, unidade,
                    output binario, ocupado, pronto, erro);
`else
    modport master (output start, dezena, unidade,
                    input  binario, ocupado, pronto);
    modport slave  (input  start, dezena, unidade,
                    output binario, ocupado, pronto);
`endif

endinterface

// File: rtl/bcd_para_binario_corrige_digito.sv
// Reverse double-dabble correction cell: subtracts 3 from a BCD field >= 8.
module corrige_digito (
    input  logic [3:0] digito,
    output logic [3:0] corrigido
);

    assign corrigido = (digito >= 4'd8) ? (digito - 4'd3) : digito;

endmodule

// File: rtl/bcd_para_binario.sv
// Sequential two-digit BCD-to-binary converter (reverse double-dabble, one
// shift per clock). Optional macro BCD_BIN_ERRO_EN adds the erro output.
module bcd_para_binario #(
    parameter int unsigned N_BITS         = 7,
    parameter int unsigned CODIGO_TRACO   = bcd_para_binario_pkg::CODIGO_TRACO,
    parameter int unsigned CODIGO_APAGADO = bcd_para_binario_pkg::CODIGO_APAGADO
) (
    input  logic              clock,
    input  logic              reset_n,
    bcd_para_binario_if.slave bus
);

    import bcd_para_binario_pkg::*;

    localparam int unsigned W_REG = N_BITS + 8;
    localparam int unsigned W_CNT = $clog2(N_BITS);

    estado_t           estado, estado_prox;
    logic [W_REG-1:0]  reg_desl;
    logic [W_REG-1:0]  desl;
    logic [W_REG-1:0]  corrigido;
    logic [3:0]        dez_corr;
    logic [3:0]        uni_corr;
    logic [W_CNT-1:0]  contador;
    logic [N_BITS-1:0] binario_r;
    logic              fora_faixa;
    logic              par_apagado;
    logic              ultimo;

    assign fora_faixa  = (bus.dezena > 4'd9) || (bus.unidade > 4'd9);
    assign par_apagado = (bus.dezena == DIGITO_APAGADO) && (bus.unidade == DIGITO_APAGADO);
    assign ultimo      = (contador == W_CNT'(N_BITS - 1));

    // Correction acts on the already-shifted digit fields.
    assign desl = reg_desl >> 1;

    corrige_digito u_corr_dez (
        .digito    (desl[W_REG-1 -: 4]),
        .corrigido (dez_corr)
    );

    corrige_digito u_corr_uni (
        .digito    (desl[N_BITS+3 -: 4]),
        .corrigido (uni_corr)
    );

    assign corrigido = {dez_corr, uni_corr, desl[N_BITS-1:0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO: begin
                if (bus.start) begin
                    estado_prox = fora_faixa ? PRONTO : CONVERTE;
                end
            end
            CONVERTE: begin
                if (ultimo) begin
                    estado_prox = PRONTO;
                end
            end
            PRONTO:  estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_desl  <= '0;
            contador  <= '0;
            binario_r <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (bus.start) begin
                        if (fora_faixa) begin
                            // 14/14 is blank; 15/15 and every other out-of-range pair is dash.
                            binario_r <= par_apagado ? N_BITS'(CODIGO_APAGADO) : N_BITS'(CODIGO_TRACO);
                        end else begin
                            reg_desl <= {bus.dezena, bus.unidade, {N_BITS{1'b0}}};
                            contador <= '0;
                        end
                    end
                end
                CONVERTE: begin
                    reg_desl <= corrigido;
                    contador <= contador + 1'b1;
                    if (ultimo) begin
                        binario_r <= corrigido[N_BITS-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_BIN_ERRO_EN
    logic par_traco;
    logic invalido;
    logic erro_r;

    assign par_traco = (bus.dezena == DIGITO_TRACO) && (bus.unidade == DIGITO_TRACO);
    assign invalido  = fora_faixa && !par_traco && !par_apagado;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            erro_r <= 1'b0;
        end else if ((estado == OCIOSO) && bus.start) begin
            erro_r <= invalido;
        end
    end

    assign bus.erro = erro_r;
`endif

    assign bus.binario = binario_r;
    assign bus.ocupado = (estado != OCIOSO);
    assign bus.pronto  = (estado == PRONTO);

endmodule

// File: tb/tb_bcd_para_binario.sv
// Scoreboard bench for bcd_para_binario: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever pronto is seen.
module tb_bcd_para_binario;

    typedef struct {
        logic [6:0] bin;
        logic       erro;
        int         ciclo;
    } esperado_t;

    logic clock;
    logic reset_n;
    int   ciclo;
    int   compared;
    int   mismatched;
    logic pronto_ant;

    esperado_t fila[$];

    bcd_para_binario_if #(.N_BITS(7)) bus ();

    bcd_para_binario #(
        .N_BITS         (7),
        .CODIGO_TRACO   (125),
        .CODIGO_APAGADO (124)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial ciclo = 0;
    always @(posedge clock) ciclo++;

    task automatic verifica(input string nome, input int atual, input int esperado);
        compared++;
        if (atual != esperado) begin
            mismatched++;
            $display("FAIL %s: obtido=%0d esperado=%0d (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // Monitor: checks every pronto against the scoreboard, plus pulse width.
    initial pronto_ant = 1'b0;
    always @(negedge clock) begin
        if (bus.pronto === 1'b1) begin
            esperado_t e;
            verifica("pronto_largura", int'(pronto_ant), 0);
            if (fila.size() == 0) begin
                verifica("pronto_inesperado", 1, 0);
            end else begin
                e = fila.pop_front();
                verifica("binario", int'(bus.binario), int'(e.bin));
                verifica("latencia", ciclo, e.ciclo);
`ifdef BCD_BIN_ERRO_EN
                verifica("erro", int'(bus.erro), int'(e.erro));
`endif
            end
        end
        pronto_ant = (bus.pronto === 1'b1);
    end

    task automatic empilha(input logic [6:0] bin, input logic erro, input int ciclo_esp);
        esperado_t e;
        e.bin   = bin;
        e.erro  = erro;
        e.ciclo = ciclo_esp;
        fila.push_back(e);
    endtask

    task automatic aguardar_fim();
        int n;
        n = 0;
        @(negedge clock);
        while (bus.ocupado !== 1'b0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) verifica("timeout_ocupado", 1, 0);
    endtask

    // Issues one start pulse; the pronto cycle is relative to the sampling edge.
    task automatic converte(input logic [3:0] d, input logic [3:0] u,
                            input logic [6:0] bin, input logic erro, input bit especial);
        @(negedge clock);
        bus.start   = 1'b1;
        bus.dezena  = d;
        bus.unidade = u;
        @(posedge clock);
        #1;
        empilha(bin, erro, ciclo + (especial ? 0 : 7));
        @(negedge clock);
        bus.start = 1'b0;
        verifica("ocupado_apos_start", int'(bus.ocupado), 1);
        aguardar_fim();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: obtido=sem_fim esperado=fim");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        compared    = 0;
        mismatched  = 0;
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.dezena  = 4'd0;
        bus.unidade = 4'd0;
        repeat (3) @(negedge clock);
        verifica("reset_binario", int'(bus.binario), 0);
        verifica("reset_ocupado", int'(bus.ocupado), 0);
        verifica("reset_pronto", int'(bus.pronto), 0);
`ifdef BCD_BIN_ERRO_EN
        verifica("reset_erro", int'(bus.erro), 0);
`endif
        reset_n = 1'b1;

        converte(4'd4, 4'd2, 7'd42, 1'b0, 1'b0);
        converte(4'd0, 4'd0, 7'd0, 1'b0, 1'b0);
        converte(4'd9, 4'd9, 7'd99, 1'b0, 1'b0);
        converte(4'd1, 4'd0, 7'd10, 1'b0, 1'b0);
        converte(4'd15, 4'd15, 7'd125, 1'b0, 1'b1);
        converte(4'd14, 4'd14, 7'd124, 1'b0, 1'b1);
        converte(4'd3, 4'd12, 7'd125, 1'b1, 1'b1);
`ifdef BCD_BIN_ERRO_EN
        repeat (2) @(negedge clock);
        verifica("erro_mantido", int'(bus.erro), 1);
`endif
        converte(4'd2, 4'd0, 7'd20, 1'b0, 1'b0);
        verifica("binario_mantido", int'(bus.binario), 20);

        // Reset in cycle 4 of a 5/7 conversion: aborted, no pronto.
        @(negedge clock);
        bus.start = 1'b1; bus.dezena = 4'd5; bus.unidade = 4'd7;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        @(negedge clock);
        verifica("abort_binario", int'(bus.binario), 0);
        verifica("abort_ocupado", int'(bus.ocupado), 0);
        verifica("abort_pronto", int'(bus.pronto), 0);
        #2 reset_n = 1'b1;
        repeat (10) @(negedge clock);
        verifica("abort_binario_pos", int'(bus.binario), 0);

        // start in cycle 3 of a 6/3 conversion is ignored.
        @(negedge clock);
        bus.start = 1'b1; bus.dezena = 4'd6; bus.unidade = 4'd3;
        @(posedge clock);
        #1;
        empilha(7'd63, 1'b0, ciclo + 7);
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        bus.start = 1'b1; bus.dezena = 4'd1; bus.unidade = 4'd1;
        @(negedge clock);
        bus.start = 1'b0;
        aguardar_fim();

        // start held high: back-to-back 63 then 25; digit change mid-run has no effect.
        @(negedge clock);
        bus.start = 1'b1; bus.dezena = 4'd6; bus.unidade = 4'd3;
        @(posedge clock);
        #1;
        empilha(7'd63, 1'b0, ciclo + 7);
        bus.dezena = 4'd2; bus.unidade = 4'd5;
        n = 0;
        @(negedge clock);
        while (bus.pronto !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) verifica("timeout_pronto", 1, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        empilha(7'd25, 1'b0, ciclo + 7);
        @(negedge clock);
        bus.start = 1'b0;
        aguardar_fim();

        for (int d = 0; d < 10; d++) begin
            for (int u = 0; u < 10; u++) begin
                converte(4'(d), 4'(u), 7'(10 * d + u), 1'b0, 1'b0);
            end
        end

        repeat (5) @(negedge clock);
        verifica("fila_vazia", fila.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
